// File: rtl/lcd_pkg.sv
// +----------------------------------------------------------------------+
// | lcd_pkg : shared constants and address helpers for lcd_controller    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package lcd_pkg;

    localparam int         STATE_W     = 2;
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CLEARING = 2'd1;
    localparam logic [1:0] ST_BUSY     = 2'd2;

    localparam logic [7:0] SPACE_CHAR  = 8'h20;
    localparam logic [6:0] LINE0_END   = 7'h27;
    localparam logic [6:0] LINE1_START = 7'h40;
    localparam logic [6:0] LINE1_END   = 7'h67;
    localparam logic [6:0] LINE_LEN    = 7'd40;
    localparam int         DDRAM_CELLS = 80;
    localparam logic [6:0] CELL_COUNT  = 7'd80;

    // Opcode masks, listed from highest decode priority to lowest
    localparam logic [7:0] OP_SET_DDRAM = 8'h80;
    localparam logic [7:0] OP_NO_EFFECT = 8'h70;
    localparam logic [7:0] OP_DISPLAY   = 8'h08;
    localparam logic [7:0] OP_ENTRY     = 8'h04;
    localparam logic [7:0] OP_HOME      = 8'h02;
    localparam logic [7:0] OP_CLEAR     = 8'h01;

    function automatic logic ac_valid(input logic [6:0] a);
        return (a <= LINE0_END) || ((a >= LINE1_START) && (a <= LINE1_END));
    endfunction

    function automatic logic [6:0] ac_to_index(input logic [6:0] a);
        return (a >= LINE1_START) ? (a - LINE1_START + LINE_LEN) : a;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        logic [6:0] n;
        n = a;
        if (inc) begin
            if (a == LINE0_END)      n = LINE1_START;
            else if (a == LINE1_END) n = 7'h00;
            else                     n = a + 7'd1;
        end else begin
            if (a == 7'h00)            n = LINE1_END;
            else if (a == LINE1_START) n = LINE0_END;
            else                       n = a - 7'd1;
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_ddram.sv
// +----------------------------------------------------------------------+
// | lcd_ddram : 80x8 display RAM, one write port, two registered reads   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [6:0] wr_idx,
    input  logic [7:0] wr_data,
    input  logic [6:0] bus_idx,
    output logic [7:0] bus_data,
    input  logic [6:0] dbg_idx,
    output logic [7:0] dbg_data
);

    logic [7:0] r_mem [DDRAM_CELLS];
    logic [7:0] r_bus;
    logic [7:0] r_dbg;

    always_ff @(posedge clk) begin
        if (wr_en && (wr_idx < CELL_COUNT)) begin
            r_mem[wr_idx] <= wr_data;
        end
    end

    // Reads see the pre-write contents when addressing the cell being written
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus <= 8'h00;
            r_dbg <= 8'h00;
        end else begin
            r_bus <= (bus_idx < CELL_COUNT) ? r_mem[bus_idx] : 8'h00;
            r_dbg <= (dbg_idx < CELL_COUNT) ? r_mem[dbg_idx] : 8'h00;
        end
    end

    assign bus_data = r_bus;
    assign dbg_data = r_dbg;

endmodule

`default_nettype wire

// File: rtl/lcd_controller.sv
// +----------------------------------------------------------------------+
// | lcd_controller : HD44780-style character LCD controller model        |
// | Optional LCD_DROP_FLAG_EN adds sticky write_dropped output.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module lcd_controller
    import lcd_pkg::*;
#(
    parameter int BUSY_CYCLES  = 40,
    parameter int CLEAR_CYCLES = 1520
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] lcd_data_in,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       busy,
    input  logic [6:0] disp_addr,
    output logic [7:0] disp_char
`ifdef LCD_DROP_FLAG_EN
    ,
    output logic       write_dropped
`endif
);

    localparam int CNT_W = $clog2(((CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES) + 1);
    localparam logic [CNT_W-1:0] C_BUSY_LOAD = CNT_W'(BUSY_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_HOME_LOAD = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TAIL_LOAD = CNT_W'((CLEAR_CYCLES > DDRAM_CELLS) ? (CLEAR_CYCLES - DDRAM_CELLS - 1) : 0);
    localparam logic [CNT_W-1:0] C_LAST_CELL = CNT_W'(DDRAM_CELLS - 1);
    localparam logic             C_HAS_TAIL  = (CLEAR_CYCLES > DDRAM_CELLS);

    logic [STATE_W-1:0] r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [6:0]         r_ac;
    logic               r_id;
    logic               r_e_q;
    logic               r_disp, r_cur, r_blink;
    logic               r_oe, r_rd_rs;
    logic [7:0]         r_status;

    logic       w_busy, w_fall, w_accept;
    logic       w_data_wr, w_data_rd, w_instr;
    logic       w_clearing;
    logic [7:0] w_bus_q;

    assign w_busy     = (r_state != ST_IDLE);
    assign w_clearing = (r_state == ST_CLEARING);
    assign w_fall     = r_e_q & ~lcd_e;
    assign w_accept   = w_fall & ~w_busy;
    assign w_data_wr  = w_accept &  lcd_rs & ~lcd_rw;
    assign w_data_rd  = w_accept &  lcd_rs &  lcd_rw;
    assign w_instr    = w_accept & ~lcd_rs & ~lcd_rw;

    lcd_ddram u_ddram (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (~reset & (w_clearing | w_data_wr)),
        .wr_idx   (w_clearing ? r_cnt[6:0] : ac_to_index(r_ac)),
        .wr_data  (w_clearing ? SPACE_CHAR : lcd_data_in),
        .bus_idx  (ac_to_index(r_ac)),
        .bus_data (w_bus_q),
        .dbg_idx  (ac_valid(disp_addr) ? ac_to_index(disp_addr) : 7'h7F),
        .dbg_data (disp_char)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_CLEARING;
            r_cnt    <= '0;
            r_ac     <= 7'h00;
            r_id     <= 1'b1;
            r_e_q    <= 1'b0;
            r_disp   <= 1'b0;
            r_cur    <= 1'b0;
            r_blink  <= 1'b0;
            r_oe     <= 1'b0;
            r_rd_rs  <= 1'b0;
            r_status <= 8'h00;
        end else begin
            r_e_q    <= lcd_e;
            r_oe     <= lcd_e & lcd_rw;
            r_rd_rs  <= lcd_rs;
            r_status <= {w_busy, r_ac};
            case (r_state)
                ST_CLEARING: begin
                    if (r_cnt == C_LAST_CELL) begin
                        r_cnt   <= C_TAIL_LOAD;
                        r_state <= C_HAS_TAIL ? ST_BUSY : ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) r_state <= ST_IDLE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                default: begin
                    if (w_data_wr || w_data_rd) begin
                        r_ac    <= ac_step(r_ac, r_id);
                        r_state <= ST_BUSY;
                        r_cnt   <= C_BUSY_LOAD;
                    end else if (w_instr) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= C_BUSY_LOAD;
                        if ((lcd_data_in & OP_SET_DDRAM) != 8'h00) begin
                            r_ac <= ac_valid(lcd_data_in[6:0]) ? lcd_data_in[6:0] : 7'h00;
                        end else if ((lcd_data_in & OP_NO_EFFECT) != 8'h00) begin
                            r_ac <= r_ac;
                        end else if ((lcd_data_in & OP_DISPLAY) != 8'h00) begin
                            r_disp  <= lcd_data_in[2];
                            r_cur   <= lcd_data_in[1];
                            r_blink <= lcd_data_in[0];
                        end else if ((lcd_data_in & OP_ENTRY) != 8'h00) begin
                            r_id <= lcd_data_in[1];
                        end else if ((lcd_data_in & OP_HOME) != 8'h00) begin
                            r_ac  <= 7'h00;
                            r_cnt <= C_HOME_LOAD;
                        end else if ((lcd_data_in & OP_CLEAR) != 8'h00) begin
                            r_ac    <= 7'h00;
                            r_id    <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= ST_CLEARING;
                        end
                    end
                end
            endcase
        end
    end

`ifdef LCD_DROP_FLAG_EN
    logic r_dropped;

    always_ff @(posedge clk) begin
        if (reset)                           r_dropped <= 1'b0;
        else if (w_fall && !lcd_rw && w_busy) r_dropped <= 1'b1;
    end

    assign write_dropped = r_dropped;
`endif

    assign lcd_data_out = r_oe ? (r_rd_rs ? w_bus_q : r_status) : 8'h00;
    assign lcd_data_oe  = r_oe;
    assign display_on   = r_disp;
    assign cursor_on    = r_cur;
    assign blink_on     = r_blink;
    assign busy         = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_lcd_controller.sv
// +----------------------------------------------------------------------+
// | tb_lcd_controller : scoreboard bench for lcd_controller              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_lcd_controller;

    localparam int K_BUS   = 0;
    localparam int K_DBG   = 1;
    localparam int K_PROBE = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] lcd_data_in = 8'h00;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe, display_on, cursor_on, blink_on, busy;
    logic [6:0] disp_addr = 7'h00;
    logic [7:0] disp_char;
`ifdef LCD_DROP_FLAG_EN
    logic       write_dropped;
`endif

    lcd_controller dut (
        .clk          (clk),
        .reset        (reset),
        .lcd_data_in  (lcd_data_in),
        .lcd_rs       (lcd_rs),
        .lcd_rw       (lcd_rw),
        .lcd_e        (lcd_e),
        .lcd_data_out (lcd_data_out),
        .lcd_data_oe  (lcd_data_oe),
        .display_on   (display_on),
        .cursor_on    (cursor_on),
        .blink_on     (blink_on),
        .busy         (busy),
        .disp_addr    (disp_addr),
        .disp_char    (disp_char)
`ifdef LCD_DROP_FLAG_EN
        ,
        .write_dropped(write_dropped)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   run_len = 0;
    int   last_run = 0;
    logic dbg_issue = 1'b0, dbg_pend = 1'b0;
    logic probe_issue = 1'b0, probe_pend = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic observe(input int kind, input logic [7:0] act);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_output: kind %0d got 0x%0h expected nothing", kind, act);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s: output kind %0d got 0x%0h expected kind %0d", e.name, kind, act, e.kind);
            end else begin
                check(e.name, {24'h0, act}, {24'h0, e.val});
            end
        end
    endtask

    always @(posedge clk) begin
        dbg_pend   <= dbg_issue;
        probe_pend <= probe_issue;
    end

    // Monitor: compare whatever the DUT presents against the queue head
    always @(negedge clk) begin
        if (!reset) begin
            if (lcd_data_oe) observe(K_BUS, lcd_data_out);
            if (dbg_pend)    observe(K_DBG, disp_char);
            if (probe_pend)  observe(K_PROBE, {3'b000, lcd_data_oe, busy, display_on, cursor_on, blink_on});
        end
    end

    // Length of the most recently completed busy interval
    always @(negedge clk) begin
        if (reset) begin
            run_len = 0;
        end else if (busy === 1'b1) begin
            run_len++;
        end else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
    end

    function automatic exp_t mk(input int kind, input logic [7:0] v, input string nm);
        exp_t e;
        e.kind = kind;
        e.val  = v;
        e.name = nm;
        return e;
    endfunction

    task automatic do_reset(input int n);
        @(posedge clk); #1 reset = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] d);
        @(posedge clk); #1 lcd_rs = rs; lcd_rw = 1'b0; lcd_data_in = d; lcd_e = 1'b1;
        @(posedge clk); #1 lcd_e = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic bus_read(input logic rs, input logic [7:0] exp, input string nm);
        sb.push_back(mk(K_BUS, exp, nm));
        @(posedge clk); #1 lcd_rs = rs; lcd_rw = 1'b1; lcd_e = 1'b1;
        @(posedge clk); #1 lcd_e = 1'b0;
        @(posedge clk); #1 lcd_rw = 1'b0;
    endtask

    task automatic dbg_read(input logic [6:0] a, input logic [7:0] exp);
        sb.push_back(mk(K_DBG, exp, $sformatf("disp_char[%02h]", a)));
        @(posedge clk); #1 disp_addr = a; dbg_issue = 1'b1;
        @(posedge clk); #1 dbg_issue = 1'b0;
    endtask

    task automatic probe(input logic [7:0] exp, input string nm);
        sb.push_back(mk(K_PROBE, exp, nm));
        @(posedge clk); #1 probe_issue = 1'b1;
        @(posedge clk); #1 probe_issue = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check({nm, "_idle_timeout"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_all_spaces(input string nm);
        logic [6:0] a;
        for (int i = 0; i < 80; i++) begin
            a = (i < 40) ? 7'(i) : 7'(i - 40 + 'h40);
            dbg_read(a, 8'h20);
        end
        wait_idle(nm);
    endtask

    initial begin
        // Power-on clear
        do_reset(3);
        probe(8'h08, "reset_flags");
        bus_read(1'b0, 8'h80, "status_while_clearing");
        wait_idle("poweron");
        check("poweron_busy_len", 32'(last_run), 32'd1520);
        bus_read(1'b0, 8'h00, "status_after_clear");
        check_all_spaces("poweron_cells");

        // Display control and two characters
        bus_write(1'b0, 8'h0E); wait_idle("disp");
        check("instr_busy_len", 32'(last_run), 32'd40);
        probe(8'h06, "display_flags");
        bus_write(1'b1, 8'h48); wait_idle("wr_h");
        bus_write(1'b1, 8'h69); wait_idle("wr_i");
        dbg_read(7'h00, 8'h48);
        dbg_read(7'h01, 8'h69);
        bus_read(1'b0, 8'h02, "ac_after_two_writes");

        // Line wraps in both directions
        bus_write(1'b0, 8'hA7); wait_idle("set27");
        bus_write(1'b1, 8'h41); wait_idle("wr27");
        dbg_read(7'h27, 8'h41);
        bus_read(1'b0, 8'h40, "inc_wrap_27_40");
        bus_write(1'b0, 8'h04); wait_idle("dec_mode");
        bus_write(1'b1, 8'h42); wait_idle("wr40");
        bus_read(1'b0, 8'h27, "dec_wrap_40_27");
        dbg_read(7'h40, 8'h42);
        bus_write(1'b0, 8'h80); wait_idle("set00");
        bus_write(1'b1, 8'h43); wait_idle("wr00");
        bus_read(1'b0, 8'h67, "dec_wrap_00_67");
        bus_write(1'b0, 8'h06); wait_idle("inc_mode");
        bus_write(1'b1, 8'h44); wait_idle("wr67");
        bus_read(1'b0, 8'h00, "inc_wrap_67_00");
        dbg_read(7'h67, 8'h44);
        dbg_read(7'h00, 8'h43);

        // Accesses while busy: status read allowed, writes dropped
        bus_write(1'b0, 8'h85); wait_idle("set05");
        bus_write(1'b1, 8'h55);
        bus_read(1'b0, 8'h86, "status_while_busy");
        bus_write(1'b1, 8'h66);
        bus_write(1'b0, 8'h08);
        wait_idle("dropped");
        check("busy_not_extended", 32'(last_run), 32'd40);
        dbg_read(7'h05, 8'h55);
        dbg_read(7'h06, 8'h20);
        bus_read(1'b0, 8'h06, "ac_after_drop");
        probe(8'h06, "flags_after_drop");
`ifdef LCD_DROP_FLAG_EN
        check("write_dropped_set", 32'(write_dropped), 32'd1);
`endif

        // Invalid address and data read
        bus_write(1'b0, 8'hFF); wait_idle("set_invalid");
        bus_read(1'b0, 8'h00, "invalid_addr_forced_0");
        bus_read(1'b1, 8'h43, "data_read_ddram0");
        wait_idle("data_read");
        check("data_read_busy_len", 32'(last_run), 32'd40);
        bus_read(1'b0, 8'h01, "ac_after_data_read");

        // Clear instruction restores I/D=1, home resets AC only
        bus_write(1'b0, 8'h04); wait_idle("dec_mode2");
        bus_write(1'b0, 8'h01); wait_idle("clear");
        check("clear_busy_len", 32'(last_run), 32'd1520);
        bus_read(1'b0, 8'h00, "ac_after_clear");
        bus_write(1'b1, 8'h4A); wait_idle("wr_after_clear");
        bus_read(1'b0, 8'h01, "id_set_by_clear");
        dbg_read(7'h00, 8'h4A);
        dbg_read(7'h05, 8'h20);
        dbg_read(7'h27, 8'h20);
        bus_write(1'b0, 8'h90); wait_idle("set10");
        bus_write(1'b0, 8'h02); wait_idle("home");
        check("home_busy_len", 32'(last_run), 32'd1520);
        bus_read(1'b0, 8'h00, "ac_after_home");

        // Reset in the middle of the clear sweep restarts it
        do_reset(1);
        bus_read(1'b0, 8'h80, "status_mid_clear");
        repeat (37) @(posedge clk);
        #1;
        do_reset(1);
        wait_idle("reclear");
        check("reclear_busy_len", 32'(last_run), 32'd1520);
        probe(8'h00, "flags_after_reset");
`ifdef LCD_DROP_FLAG_EN
        check("write_dropped_cleared", 32'(write_dropped), 32'd0);
`endif
        check_all_spaces("reclear_cells");

        repeat (5) @(posedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no output observed, expected 0x%0h", e.name, e.val);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
